snake_body_controller: RTL

//  Owns the snake state that feeds the VGA controller's x_values/y_values buses: head/body

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_step_timer.sv | 29 ++
 rtl/snake_body_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and defaults for the snake body controller and its step timer.
package snake_pkg;

  localparam int GRID_W_DEF      = 10;
  localparam int GRID_H_DEF      = 10;
  localparam int MAX_LEN_DEF     = 100;
  localparam int STEP_CYCLES_DEF = 6_250_000;

  localparam logic [31:0] EMPTY_LANE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CALC,
    ST_CHECK,
    ST_COMMIT,
    ST_DONE
  } state_t;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (2'(a) ^ 2'(b)) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Free-running step period counter; tick marks the last cycle of each period.
module snake_step_timer #(
  parameter int STEP_CYCLES = 6_250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/snake_body_controller.sv
// Snake state owner: moves the head one tile per step, shifts the body behind it,
// grows on request and stops the game on wall or self collision.
module snake_body_controller
  import snake_pkg::*;
#(
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir_valid,
  input  logic [1:0]            dir_code,
  input  logic                  grow,
  output logic [32*MAX_LEN-1:0] x_values,
  output logic [32*MAX_LEN-1:0] y_values,
  output logic [6:0]            length,
  output logic                  game_done,
  output logic                  step_pulse
);

  localparam int          IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0]  LEN_MAX  = 7'(MAX_LEN);
  localparam logic [31:0] CENTER_X = 32'(GRID_W / 2);
  localparam logic [31:0] CENTER_Y = 32'(GRID_H / 2);
  localparam logic [31:0] LAST_X   = 32'(GRID_W - 1);
  localparam logic [31:0] LAST_Y   = 32'(GRID_H - 1);

  logic [31:0] lane_x [MAX_LEN];
  logic [31:0] lane_y [MAX_LEN];

  state_t      state;
  dir_t        cur_dir, next_dir;
  logic        grow_pend, grow_now;
  logic [31:0] head_x, head_y;
  logic [IW-1:0] scan_idx;
  logic [6:0]  scan_limit;

  logic        tick;
  logic [31:0] cand_x, cand_y;
  logic        wall_hit, lane_hit, grow_take, dir_open, grow_open;
  logic [6:0]  calc_limit;

  snake_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_RUN),
    .clear  (state != ST_RUN),
    .tick   (tick)
  );

  always_comb begin
    cand_x   = lane_x[0];
    cand_y   = lane_y[0];
    wall_hit = 1'b0;
    case (cur_dir)
      DIR_UP:    if (lane_y[0] == 32'd0)  wall_hit = 1'b1; else cand_y = lane_y[0] - 32'd1;
      DIR_RIGHT: if (lane_x[0] == LAST_X) wall_hit = 1'b1; else cand_x = lane_x[0] + 32'd1;
      DIR_DOWN:  if (lane_y[0] == LAST_Y) wall_hit = 1'b1; else cand_y = lane_y[0] + 32'd1;
      default:   if (lane_x[0] == 32'd0)  wall_hit = 1'b1; else cand_x = lane_x[0] - 32'd1;
    endcase
  end

  // The tail is excluded from the scan unless growing, since it vacates this step.
  assign grow_take  = (grow_pend || grow) && (length < LEN_MAX);
  assign calc_limit = grow_take ? length : length - 7'd1;
  assign lane_hit   = (lane_x[scan_idx] == head_x) && (lane_y[scan_idx] == head_y);
  assign dir_open   = (state == ST_RUN) || (state == ST_CALC) ||
                      (state == ST_CHECK) || (state == ST_COMMIT);
  assign grow_open  = (state == ST_RUN) || (state == ST_CHECK) || (state == ST_COMMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_dir    <= DIR_RIGHT;
      next_dir   <= DIR_RIGHT;
      grow_pend  <= 1'b0;
      grow_now   <= 1'b0;
      head_x     <= '0;
      head_y     <= '0;
      scan_idx   <= '0;
      scan_limit <= '0;
      length     <= 7'd1;
      game_done  <= 1'b0;
      step_pulse <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        lane_x[i] <= (i == 0) ? CENTER_X : EMPTY_LANE;
        lane_y[i] <= (i == 0) ? CENTER_Y : EMPTY_LANE;
      end
    end else begin
      step_pulse <= 1'b0;
      if (dir_valid && dir_open && !is_reverse(dir_t'(dir_code), cur_dir))
        next_dir <= dir_t'(dir_code);
      if (grow && grow_open && (length < LEN_MAX))
        grow_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            state   <= ST_CALC;
            cur_dir <= next_dir;
          end
        end
        ST_CALC: begin
          grow_now   <= grow_take;
          grow_pend  <= 1'b0;
          head_x     <= cand_x;
          head_y     <= cand_y;
          scan_idx   <= '0;
          scan_limit <= calc_limit;
          if (wall_hit) begin
            state     <= ST_DONE;
            game_done <= 1'b1;
          end else if (calc_limit == 7'd0) begin
            state <= ST_COMMIT;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (lane_hit) begin
            state     <= ST_DONE;
            game_done <= 1'b1;
          end else if (7'(scan_idx) + 7'd1 == scan_limit) begin
            state <= ST_COMMIT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_COMMIT: begin
          lane_x[0] <= head_x;
          lane_y[0] <= head_y;
          for (int i = 1; i < MAX_LEN; i++) begin
            if (i == int'(length) && !grow_now) begin
              lane_x[i] <= EMPTY_LANE;
              lane_y[i] <= EMPTY_LANE;
            end else begin
              lane_x[i] <= lane_x[i-1];
              lane_y[i] <= lane_y[i-1];
            end
          end
          if (grow_now) length <= length + 7'd1;
          step_pulse <= 1'b1;
          state      <= ST_RUN;
        end
        ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            cur_dir   <= DIR_RIGHT;
            next_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            length    <= 7'd1;
            game_done <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
              lane_x[i] <= (i == 0) ? CENTER_X : EMPTY_LANE;
              lane_y[i] <= (i == 0) ? CENTER_Y : EMPTY_LANE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign x_values[32*g +: 32] = lane_x[g];
    assign y_values[32*g +: 32] = lane_y[g];
  end

endmodule
